mux21_arb: RTL and testbench

Two-requester round-robin arbiter that owns the select line of a `mux21` 2-1 selector. Requester 0 drives `D0` and requester 1 drives `D1`. The arbiter decides which of them reaches `Y`, and it bounds each tenure to `HOLD` cycles when the other side is waiting. It sits directly in front of the `mux21` instance: its `S1` output connects to the mux `S1` input, and its grants tell each requester when its data is being passed through.

---
 rtl/mux21_arb_if.sv | 20 ++
 rtl/mux21_arb.sv | 100 ++++++++++
 tb/tb_mux21_arb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mux21_arb_if.sv
// Request/grant bundle between two requesters and the mux21 select arbiter.
interface mux21_arb_if;
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic s1;
    logic busy;
    logic gstart;

    modport master (
        output req0, req1,
        input  gnt0, gnt1, s1, busy, gstart
    );

    modport slave (
        input  req0, req1,
        output gnt0, gnt1, s1, busy, gstart
    );
endinterface

// File: rtl/mux21_arb.sv
// Two-requester round-robin arbiter driving the mux21 select line.
// Each tenure is capped at HOLD cycles only while the other side is waiting.
module mux21_arb #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned CW   = 3
) (
    input  logic        clk,
    input  logic        rst,
    mux21_arb_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

    logic [1:0]    state, state_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          s1_nxt;
    logic          gstart_nxt;
    logic          go0, go1;

    // Next-state, tenure counter and select decision.
    always_comb begin
        state_nxt  = state;
        last_nxt   = last;
        cnt_nxt    = cnt;
        s1_nxt     = bus.s1;
        gstart_nxt = 1'b0;
        go0        = 1'b0;
        go1        = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req0 && (!bus.req1 || last)) go0 = 1'b1;
                else if (bus.req1)                   go1 = 1'b1;
            end
            OWN0: begin
                if (!bus.req0 || (bus.req1 && cnt == HOLD_LAST)) begin
                    last_nxt = 1'b0;
                    if (bus.req1) go1 = 1'b1;
                    else          state_nxt = IDLE;
                end else begin
                    // Wrap keeps an uncontested tenure open indefinitely.
                    cnt_nxt = (cnt == HOLD_LAST) ? '0 : cnt + CW'(1);
                end
            end
            OWN1: begin
                if (!bus.req1 || (bus.req0 && cnt == HOLD_LAST)) begin
                    last_nxt = 1'b1;
                    if (bus.req0) go0 = 1'b1;
                    else          state_nxt = IDLE;
                end else begin
                    cnt_nxt = (cnt == HOLD_LAST) ? '0 : cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Entering a tenure: restart the counter, steer the mux, flag the start.
        if (go0) begin
            state_nxt  = OWN0;
            cnt_nxt    = '0;
            s1_nxt     = 1'b0;
            gstart_nxt = 1'b1;
        end
        if (go1) begin
            state_nxt  = OWN1;
            cnt_nxt    = '0;
            s1_nxt     = 1'b1;
            gstart_nxt = 1'b1;
        end
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            cnt        <= '0;
            bus.gnt0   <= 1'b0;
            bus.gnt1   <= 1'b0;
            bus.s1     <= 1'b0;
            bus.busy   <= 1'b0;
            bus.gstart <= 1'b0;
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            cnt        <= cnt_nxt;
            bus.gnt0   <= (state_nxt == OWN0);
            bus.gnt1   <= (state_nxt == OWN1);
            bus.s1     <= s1_nxt;
            bus.busy   <= (state_nxt != IDLE);
            bus.gstart <= gstart_nxt;
        end
    end

endmodule

// File: tb/tb_mux21_arb.sv
// Directed scoreboard bench for mux21_arb: HOLD=4 instance plus a HOLD=1 instance.
module tb_mux21_arb;

    logic clk;
    logic rst;

    mux21_arb_if a_if ();
    mux21_arb_if b_if ();

    mux21_arb #(.HOLD(4), .CW(3)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    mux21_arb #(.HOLD(1), .CW(3)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit    sel;
        logic  g0;
        logic  g1;
        logic  s1;
        logic  busy;
        logic  gs;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic cmp(input string tag, input string field, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s %s observed=%b expected=%b", tag, field, obs, exp);
        end
    endtask

    task automatic push(input bit sel, input logic g0, input logic g1,
                        input logic s1, input logic gs, input string tag);
        exp_t e;
        e.sel = sel; e.g0 = g0; e.g1 = g1; e.s1 = s1; e.gs = gs;
        e.busy = g0 | g1;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic o0, o1, os, ob, og;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        if (e.sel) begin
            o0 = b_if.gnt0; o1 = b_if.gnt1; os = b_if.s1; ob = b_if.busy; og = b_if.gstart;
        end else begin
            o0 = a_if.gnt0; o1 = a_if.gnt1; os = a_if.s1; ob = a_if.busy; og = a_if.gstart;
        end
        cmp(e.tag, "gnt0",   o0, e.g0);
        cmp(e.tag, "gnt1",   o1, e.g1);
        cmp(e.tag, "s1",     os, e.s1);
        cmp(e.tag, "busy",   ob, e.busy);
        cmp(e.tag, "gstart", og, e.gs);
        cmp(e.tag, "mutex",  o0 & o1, 1'b0);
    endtask

    // Drive requests on one DUT, then compare just after the following rising edge.
    task automatic step(input bit sel, input logic r0, input logic r1,
                        input logic g0, input logic g1, input logic s1,
                        input logic gs, input string tag);
        a_if.req0 = sel ? 1'b0 : r0;
        a_if.req1 = sel ? 1'b0 : r1;
        b_if.req0 = sel ? r0 : 1'b0;
        b_if.req1 = sel ? r1 : 1'b0;
        push(sel, g0, g1, s1, gs, tag);
        @(posedge clk);
        #1;
        check();
    endtask

    // Asynchronous reset pulse away from any rising edge; outputs must clear at once.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
        #1;
        check();
        #4;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_if.req0 = 1'b0; a_if.req1 = 1'b0;
        b_if.req0 = 1'b0; b_if.req1 = 1'b0;

        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_a");
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_b");
        #1;
        check();
        check();
        #10;
        rst = 1'b0;

        step(0, 0, 0, 0, 0, 0, 0, "idle_after_reset");
        #4;
        step(0, 1, 0, 1, 0, 0, 1, "req0_grant");
        step(0, 1, 0, 1, 0, 0, 0, "req0_hold1");
        step(0, 1, 0, 1, 0, 0, 0, "req0_hold2");
        step(0, 0, 0, 0, 0, 0, 0, "req0_release");

        // Continuous contention from reset: four cycles each, requester 0 first.
        @(posedge clk); #1;
        pulse_reset("reset_before_contention");
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, 0, (i == 0), "cont_own0");
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1, 1, (i == 0), "cont_own1");
        step(0, 1, 1, 1, 0, 0, 1, "cont_own0_again");
        step(0, 1, 1, 1, 0, 0, 0, "cont_own0_again2");
        step(0, 0, 0, 0, 0, 0, 0, "cont_release_idle");

        // Uncontested requester 1 survives the counter wrap.
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 1, 1, (i == 0), "solo_req1");
        step(0, 0, 0, 0, 0, 1, 0, "solo_release_s1_holds");

        // Owner drops as the other side rises: direct handover.
        step(0, 1, 0, 1, 0, 0, 1, "ho_own0");
        step(0, 1, 0, 1, 0, 0, 0, "ho_own0_hold");
        step(0, 0, 1, 0, 1, 1, 1, "ho_direct_own1");
        step(0, 0, 1, 0, 1, 1, 0, "ho_own1_hold");
        step(0, 0, 0, 0, 0, 1, 0, "ho_idle_s1_holds");
        step(0, 0, 0, 0, 0, 1, 0, "ho_idle_s1_holds2");

        // Reset in the middle of a requester 1 tenure, then both request.
        step(0, 0, 1, 0, 1, 1, 1, "mid_own1");
        step(0, 0, 1, 0, 1, 1, 0, "mid_own1_hold");
        pulse_reset("mid_tenure_reset");
        step(0, 1, 1, 1, 0, 0, 1, "post_reset_req0_wins");
        step(0, 0, 0, 0, 0, 0, 0, "post_reset_release");

        // HOLD=1 instance: grants alternate every cycle under contention.
        for (int i = 0; i < 6; i++)
            step(1, 1, 1, (i % 2 == 0), (i % 2 == 1), (i % 2 == 1), 1, "hold1_alt");
        step(1, 1, 0, 1, 0, 0, 1, "hold1_handover_own0");
        step(1, 1, 0, 1, 0, 0, 0, "hold1_solo_wrap");
        step(1, 0, 0, 0, 0, 0, 0, "hold1_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
